// File: rtl/uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
package uart_pkg;

  localparam int DATA_WIDTH_MIN = 5;
  localparam int DATA_WIDTH_MAX = 9;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_t;

  // Parity bit on the line: accumulated data XOR plus one for odd parity.
  function automatic logic parity_bit(input logic acc, input logic odd);
    return acc ^ odd;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with combinational head-of-queue read data.
// A pop while empty and a push while full are ignored.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(1'b0);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == CNT_FULL);
  assign empty     = (count_r == CNT_ZERO);
  assign count     = count_r;
  assign pop_data  = mem_r[rd_ptr_r];
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy; reset flushes the queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= CNT_ZERO;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// FIFO-fed UART transmitter: LSB-first frames, runtime baud divisor, 1 or 2 stop bits.
// Define UART_TX_PARITY_EN to build the optional parity bit state.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_WIDTH  = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DIV_WIDTH-1:0]            baud_div,
  input  logic                            parity_en,
  input  logic                            parity_odd,
  input  logic [DATA_WIDTH-1:0]           in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic                            tx,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

  localparam int BW = $clog2(DATA_WIDTH+1);
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO  = DIV_WIDTH'(1'b0);
  localparam logic [DIV_WIDTH-1:0] DIV_ONE   = DIV_WIDTH'(1'b1);
  localparam logic [BW-1:0]        BIT_ZERO  = BW'(1'b0);
  localparam logic [BW-1:0]        BIT_ONE   = BW'(1'b1);
  localparam logic [BW-1:0]        BIT_LAST  = BW'(DATA_WIDTH-1);
  localparam logic [BW-1:0]        STOP_LAST = BW'(STOP_BITS-1);

  if (DATA_WIDTH < DATA_WIDTH_MIN || DATA_WIDTH > DATA_WIDTH_MAX) begin : g_bad_width
    $error("uart_tx_fifo: DATA_WIDTH out of range");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2, >= 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end

  uart_tx_state_t        state_r, state_n;
  logic [DATA_WIDTH-1:0] shift_r, shift_n;
  logic [DIV_WIDTH-1:0]  div_r, div_n;
  logic [DIV_WIDTH-1:0]  baud_cnt_r, baud_n;
  logic [BW-1:0]         bit_cnt_r, bit_n;
  logic                  tx_r, tx_n;
  logic                  busy_r;
  logic                  load_s;
  logic                  baud_done_s;
  logic                  stop_done_s;
  logic                  full_s;
  logic                  empty_s;
  logic [DATA_WIDTH-1:0] fifo_data_s;
  logic [DIV_WIDTH-1:0]  div_eff_s;

`ifdef UART_TX_PARITY_EN
  logic par_r, par_n;
  logic par_en_r, par_en_n;
  logic par_odd_r, par_odd_n;
`else
  logic unused_par_s;
  assign unused_par_s = parity_en ^ parity_odd;
`endif

  uart_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (in_valid && in_ready),
    .push_data (in_data),
    .pop       (load_s),
    .pop_data  (fifo_data_s),
    .full      (full_s),
    .empty     (empty_s),
    .count     (fifo_count)
  );

  assign in_ready    = !full_s && !rst;
  assign tx          = tx_r;
  assign busy        = busy_r;
  assign div_eff_s   = (baud_div == DIV_ZERO) ? DIV_ONE : baud_div;
  assign baud_done_s = (baud_cnt_r == DIV_ZERO);
  assign stop_done_s = (state_r == STOP) && baud_done_s && (bit_cnt_r == STOP_LAST);
  // The next frame loads from IDLE or straight out of the final stop cycle.
  assign load_s      = !empty_s && ((state_r == IDLE) || stop_done_s);

  // Next-state, shift and counter logic.
  always_comb begin
    state_n = state_r;
    shift_n = shift_r;
    div_n   = div_r;
    baud_n  = baud_cnt_r;
    bit_n   = bit_cnt_r;
`ifdef UART_TX_PARITY_EN
    par_n     = par_r;
    par_en_n  = par_en_r;
    par_odd_n = par_odd_r;
`endif
    if (load_s) begin
      state_n = START;
      shift_n = fifo_data_s;
      div_n   = div_eff_s;
      baud_n  = div_eff_s - DIV_ONE;
      bit_n   = BIT_ZERO;
`ifdef UART_TX_PARITY_EN
      par_n     = 1'b0;
      par_en_n  = parity_en;
      par_odd_n = parity_odd;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          state_n = IDLE;
        end
        START: begin
          if (baud_done_s) begin
            state_n = DATA;
            baud_n  = div_r - DIV_ONE;
            bit_n   = BIT_ZERO;
          end else begin
            baud_n = baud_cnt_r - DIV_ONE;
          end
        end
        DATA: begin
          if (baud_done_s) begin
            shift_n = {1'b0, shift_r[DATA_WIDTH-1:1]};
            baud_n  = div_r - DIV_ONE;
`ifdef UART_TX_PARITY_EN
            par_n = par_r ^ shift_r[0];
`endif
            if (bit_cnt_r == BIT_LAST) begin
              bit_n = BIT_ZERO;
`ifdef UART_TX_PARITY_EN
              state_n = par_en_r ? PARITY : STOP;
`else
              state_n = STOP;
`endif
            end else begin
              bit_n = bit_cnt_r + BIT_ONE;
            end
          end else begin
            baud_n = baud_cnt_r - DIV_ONE;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_done_s) begin
            state_n = STOP;
            baud_n  = div_r - DIV_ONE;
            bit_n   = BIT_ZERO;
          end else begin
            baud_n = baud_cnt_r - DIV_ONE;
          end
        end
`endif
        STOP: begin
          if (stop_done_s) begin
            state_n = IDLE;
          end else if (baud_done_s) begin
            bit_n  = bit_cnt_r + BIT_ONE;
            baud_n = div_r - DIV_ONE;
          end else begin
            baud_n = baud_cnt_r - DIV_ONE;
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  // Line level for the current state, registered one cycle later onto tx.
  always_comb begin
    case (state_r)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_r[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_n = parity_bit(par_r, par_odd_r);
`endif
      default: tx_n = 1'b1;
    endcase
  end

  // State and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      shift_r    <= {DATA_WIDTH{1'b0}};
      div_r      <= DIV_ZERO;
      baud_cnt_r <= DIV_ZERO;
      bit_cnt_r  <= BIT_ZERO;
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_r     <= 1'b0;
      par_en_r  <= 1'b0;
      par_odd_r <= 1'b0;
`endif
    end else begin
      state_r    <= state_n;
      shift_r    <= shift_n;
      div_r      <= div_n;
      baud_cnt_r <= baud_n;
      bit_cnt_r  <= bit_n;
      tx_r       <= tx_n;
      busy_r     <= (state_n != IDLE);
`ifdef UART_TX_PARITY_EN
      par_r     <= par_n;
      par_en_r  <= par_en_n;
      par_odd_r <= par_odd_n;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: one instance with 1 stop bit, one with 2 stop bits.
// Parity frames are exercised only when UART_TX_PARITY_EN is defined.
module tb_uart_tx_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] baud_div;
  logic        parity_en;
  logic        parity_odd;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready, tx, busy;
  logic [3:0]  fifo_count;
  logic        in_ready2, tx2, busy2;
  logic [3:0]  fifo_count2;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(8), .DIV_WIDTH(16), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst), .baud_div(baud_div), .parity_en(parity_en), .parity_odd(parity_odd),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .tx(tx), .busy(busy),
    .fifo_count(fifo_count)
  );

  uart_tx_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(8), .DIV_WIDTH(16), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .baud_div(baud_div), .parity_en(parity_en), .parity_odd(parity_odd),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready2), .tx(tx2), .busy(busy2),
    .fifo_count(fifo_count2)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] wq[$];
  logic       txq[$];
  logic       bsq[$];
  logic       tx2q[$];
  logic       bs2q[$];
  logic       rdyq[$];
  int         cntq[$];
  int         div_chg_idx = -1;
  logic [15:0] div_chg_val = 16'd0;
  int         rst_idx = -1;
  int         acc_total;
  int         first_nready_acc;
  int         max_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected frame bits, bit 0 = start bit; par: -1 none, 0 even, 1 odd.
  function automatic logic [63:0] frame_exp(input logic [7:0] d, input int stops, input int par);
    logic [63:0] v;
    int n;
    v = 64'd0;
    for (int i = 0; i < 8; i++) v[1+i] = d[i];
    n = 9;
    if (par >= 0) begin
      v[9] = (^d) ^ (par == 1);
      n = 10;
    end
    for (int s = 0; s < stops; s++) v[n+s] = 1'b1;
    return v;
  endfunction

  // Mid-bit samples of a recorded line (sel 0: dut, 1: dut2).
  function automatic logic [63:0] sample_bits(input int sel, input int start, input int div, input int nb);
    logic [63:0] v;
    v = 64'd0;
    for (int b = 0; b < nb; b++) begin
      v[b] = (sel == 0) ? txq[start + b*div + div/2] : tx2q[start + b*div + div/2];
    end
    return v;
  endfunction

  function automatic int ones(input int sel, input int lo, input int hi);
    int n;
    n = 0;
    for (int i = lo; i <= hi; i++) begin
      case (sel)
        0:       n += int'(txq[i]);
        1:       n += int'(bsq[i]);
        default: n += int'(bs2q[i]);
      endcase
    end
    return n;
  endfunction

  // Pushes wq in order while recording; sample i is taken after posedge i of the run.
  task automatic run(input int ncyc);
    int   acc;
    logic rdy;
    txq.delete(); bsq.delete(); tx2q.delete(); bs2q.delete(); rdyq.delete(); cntq.delete();
    acc = 0;
    first_nready_acc = -1;
    max_cnt = 0;
    for (int i = 0; i < ncyc; i++) begin
      rst = (i == rst_idx);
      if (i == div_chg_idx) baud_div = div_chg_val;
      if (acc < wq.size()) begin
        in_valid = 1'b1;
        in_data  = wq[acc];
      end else begin
        in_valid = 1'b0;
        in_data  = 8'h00;
      end
      #1;
      rdy = in_ready;
      @(posedge clk);
      if (in_valid && rdy) acc++;
      @(negedge clk);
      txq.push_back(tx);
      bsq.push_back(busy);
      tx2q.push_back(tx2);
      bs2q.push_back(busy2);
      rdyq.push_back(in_ready);
      cntq.push_back(int'(fifo_count));
      if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
      if (!rst && in_ready === 1'b0 && first_nready_acc < 0) first_nready_acc = acc;
    end
    in_valid = 1'b0;
    rst = 1'b0;
    acc_total = acc;
    wq.delete();
    div_chg_idx = -1;
    rst_idx = -1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [63:0] fe;
    logic [63:0] e;
    logic [63:0] g;

    rst = 1'b1; baud_div = 16'd4; parity_en = 1'b0; parity_odd = 1'b0;
    in_data = 8'h00; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_tx", 64'(tx), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_count", 64'(fifo_count), 64'd0);
    check("rst_ready_low", 64'(in_ready), 64'd0);
    check("rst_count2", 64'(fifo_count2), 64'd0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", 64'(in_ready), 64'd1);
    check("ready2_after_rst", 64'(in_ready2), 64'd1);
    @(negedge clk);

    // Single 0xA5 frame at div 4: 40 clocks, tx low from the second edge after the push.
    wq = '{8'hA5};
    run(50);
    check("t1_busy_before_load", 64'(bsq[0]), 64'd0);
    check("t1_busy_at_load", 64'(bsq[1]), 64'd1);
    check("t1_tx_idle_before_start", 64'(txq[1]), 64'd1);
    fe = frame_exp(8'hA5, 1, -1);
    e = 64'd0;
    g = 64'd0;
    for (int i = 0; i < 40; i++) begin
      e[i] = fe[i/4];
      g[i] = txq[2+i];
    end
    check("t1_wave40", g, e);
    check("t1_busy_cycles", 64'(ones(1, 0, 49)), 64'd40);
    check("t1_busy_falls", 64'(bsq[41]), 64'd0);
    check("t1_last_stop_high", 64'(txq[41]), 64'd1);
    do_reset();

`ifdef UART_TX_PARITY_EN
    // Parity frames: 0xA5 has four ones, so even parity sends 0 and odd sends 1.
    parity_en = 1'b1; parity_odd = 1'b0;
    wq = '{8'hA5};
    run(50);
    check("t2_even_frame", sample_bits(0, 2, 4, 11), frame_exp(8'hA5, 1, 0));
    check("t2_even_busy", 64'(ones(1, 0, 49)), 64'd44);
    do_reset();
    parity_odd = 1'b1;
    wq = '{8'hA5};
    run(50);
    check("t2_odd_frame", sample_bits(0, 2, 4, 11), frame_exp(8'hA5, 1, 1));
    check("t2_odd_bit", 64'(txq[2 + 9*4 + 2]), 64'd1);
    parity_en = 1'b0; parity_odd = 1'b0;
    do_reset();
`endif

    // Held valid: nine words accepted, FIFO fills to 8, nine frames back-to-back.
    wq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'hFF};
    begin
      logic [7:0] words [9];
      for (int k = 0; k < 9; k++) words[k] = wq[k];
      run(380);
      check("t3_accepted_before_full", 64'(first_nready_acc), 64'd9);
      check("t3_max_count", 64'(max_cnt), 64'd8);
      check("t3_total_accepted", 64'(acc_total), 64'd9);
      for (int k = 0; k < 9; k++) begin
        check($sformatf("t3_frame%0d", k), sample_bits(0, 2 + 40*k, 4, 10), frame_exp(words[k], 1, -1));
      end
      check("t3_busy_no_gap", 64'(ones(1, 1, 360)), 64'd360);
      check("t3_busy_end", 64'(bsq[361]), 64'd0);
    end
    do_reset();

    // Divisor change mid-frame only affects the next frame.
    baud_div = 16'd4;
    wq = '{8'hA5, 8'h3C};
    div_chg_idx = 10;
    div_chg_val = 16'd8;
    run(130);
    check("t4_frame1_div4", sample_bits(0, 2, 4, 10), frame_exp(8'hA5, 1, -1));
    check("t4_frame2_div8", sample_bits(0, 42, 8, 10), frame_exp(8'h3C, 1, -1));
    check("t4_busy_cycles", 64'(ones(1, 0, 129)), 64'd120);
    do_reset();

    // Reset during DATA of the first frame with three words queued.
    baud_div = 16'd4;
    wq = '{8'h11, 8'h22, 8'h33, 8'h44};
    rst_idx = 15;
    run(70);
    check("t5_queued_before_rst", 64'(cntq[14]), 64'd3);
    check("t5_tx_after_rst", 64'(txq[15]), 64'd1);
    check("t5_count_after_rst", 64'(cntq[15]), 64'd0);
    check("t5_busy_after_rst", 64'(bsq[15]), 64'd0);
    check("t5_ready_during_rst", 64'(rdyq[15]), 64'd0);
    check("t5_ready_after_rst", 64'(rdyq[16]), 64'd1);
    check("t5_tx_stays_high", 64'(ones(0, 15, 69)), 64'd55);
    check("t5_busy_stays_low", 64'(ones(1, 15, 69)), 64'd0);
    do_reset();

    // Divisor 0 runs at one clock per bit; second instance uses two stop bits.
    baud_div = 16'd0;
    wq = '{8'hA5, 8'h3C};
    run(30);
    check("t6_div0_frames", sample_bits(0, 2, 1, 20),
          frame_exp(8'hA5, 1, -1) | (frame_exp(8'h3C, 1, -1) << 10));
    check("t6_stop2_frames", sample_bits(1, 2, 1, 22),
          frame_exp(8'hA5, 2, -1) | (frame_exp(8'h3C, 2, -1) << 11));
    check("t6_busy_stop1", 64'(ones(1, 0, 29)), 64'd20);
    check("t6_busy_stop2", 64'(ones(2, 0, 29)), 64'd22);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
